// File: rtl/link_pkg.sv
// Constants and state type shared by the tile-to-tile serial link endpoints.
// Intended for reuse by the transmit side as well as the receiver.
package link_pkg;

   localparam int unsigned LINK_IDLE_CYCLES = 64;
   localparam int unsigned LINK_MAX_FRAME   = 1024;
   localparam int unsigned LINK_FIFO_DEPTH  = 4;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StGap   = 2'd2
   } link_rx_state_e;

endpackage

// File: rtl/link_byte_fifo.sv
// Show-ahead FIFO for received link bytes ({sof, data}).
// The head entry is visible on data_o whenever empty_o is low.
module link_byte_fifo #(
   parameter int unsigned Depth = 4,
   parameter int unsigned Width = 9
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [Width-1:0] data_i,
   input  logic             pop_i,
   output logic [Width-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AW = $clog2(Depth);
   localparam logic [AW:0] PtrOne = 1;

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [Width-1:0] mem_q [Depth];
   logic [Width-1:0] mem_d [Depth];
   logic             push_en;
   logic             pop_en;

   always_comb begin
      empty_o  = (wr_ptr_q == rd_ptr_q);
      full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      pop_en   = pop_i & ~empty_o;
      // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
      push_en  = push_i & (~full_o | pop_en);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (push_en) begin
         mem_d[wr_ptr_q[AW-1:0]] = data_i;
         wr_ptr_d                = wr_ptr_q + PtrOne;
      end
      if (pop_en) begin
         rd_ptr_d = rd_ptr_q + PtrOne;
      end
      data_o = mem_q[rd_ptr_q[AW-1:0]];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/conn_link_rx.sv
// Receive end of the tile-to-tile serial link: synchronises LINK_CLK/LINK_DAT, shifts bytes
// MSB first, delimits frames by idle gaps and hands bytes to the frame-buffer writer.
module conn_link_rx
   import link_pkg::*;
#(
   parameter int unsigned IDLE_CYCLES = LINK_IDLE_CYCLES,
   parameter int unsigned FIFO_DEPTH  = LINK_FIFO_DEPTH,
   parameter int unsigned MAX_FRAME   = LINK_MAX_FRAME
) (
   input  logic        OSC_40,
   input  logic        RESET,
   input  logic        LINK_CLK,
   input  logic        LINK_DAT,
   output logic [7:0]  RX_DATA,
   output logic        RX_SOF,
   output logic        RX_VALID,
   input  logic        RX_READY,
   output logic        RX_EOF,
   output logic [10:0] FRAME_LEN,
   output logic        ERR_FRAME,
   output logic        ERR_OVF
);

   localparam int unsigned   IdleW    = $clog2(IDLE_CYCLES + 1);
   localparam logic [IdleW-1:0] IdleMax  = IdleW'(IDLE_CYCLES);
   localparam logic [IdleW-1:0] IdleLast = IdleW'(IDLE_CYCLES - 1);
   localparam logic [10:0]   MaxFrame = 11'(MAX_FRAME);

   logic             clk_meta_q, clk_s_q, clk_d_q;
   logic             dat_meta_q, dat_s_q;
   logic             rise;

   link_rx_state_e   state_q, state_d;
   logic [7:0]       shreg_q, shreg_d;
   logic [7:0]       shift_val;
   logic [2:0]       bitcnt_q, bitcnt_d;
   logic [10:0]      bytecnt_q, bytecnt_d;
   logic             sof_pend_q, sof_pend_d;
   logic [IdleW-1:0] idle_q, idle_d;
   logic             push_q, push_d;
   logic             push_ok_q, push_ok_d;
   logic [8:0]       push_data_q, push_data_d;
   logic             eof_q, eof_d;
   logic             ferr_q, ferr_d;
   logic             ovf_q, ovf_d;
   logic [10:0]      frame_len_q, frame_len_d;

   logic             fifo_wr, fifo_pop, fifo_full, fifo_empty;
   logic [8:0]       fifo_head;

   assign rise      = clk_s_q & ~clk_d_q;
   assign shift_val = {shreg_q[6:0], dat_s_q};
   assign fifo_pop  = ~fifo_empty & RX_READY;
   assign fifo_wr   = push_q & push_ok_q & (~fifo_full | fifo_pop);

   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      bitcnt_d    = bitcnt_q;
      bytecnt_d   = bytecnt_q;
      sof_pend_d  = sof_pend_q;
      idle_d      = idle_q;
      push_d      = 1'b0;
      push_ok_d   = push_ok_q;
      push_data_d = push_data_q;
      eof_d       = 1'b0;
      ferr_d      = 1'b0;
      ovf_d       = push_q & ~fifo_wr;
      frame_len_d = frame_len_q;

      unique case (state_q)
         StShift: begin
            if (rise) begin
               shreg_d  = shift_val;
               bitcnt_d = bitcnt_q + 3'd1;
               idle_d   = '0;
               if (bitcnt_q == 3'd7) begin
                  push_d      = 1'b1;
                  push_data_d = {sof_pend_q, shift_val};
                  push_ok_d   = (bytecnt_q < MaxFrame);
                  sof_pend_d  = 1'b0;
                  if (bytecnt_q != MaxFrame) bytecnt_d = bytecnt_q + 11'd1;
               end
            end else begin
               if (idle_q != IdleMax) idle_d = idle_q + 1'b1;
               if (idle_q >= IdleLast) state_d = StGap;
            end
         end
         StGap: begin
            if (bytecnt_q != 11'd0) begin
               eof_d       = 1'b1;
               frame_len_d = bytecnt_q;
            end
            ferr_d  = (bitcnt_q != 3'd0);
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // A rise seen in IDLE, or in the single GAP cycle, opens a new frame with that bit.
      if (rise && state_q != StShift) begin
         state_d    = StShift;
         shreg_d    = {7'd0, dat_s_q};
         bitcnt_d   = 3'd1;
         bytecnt_d  = 11'd0;
         sof_pend_d = 1'b1;
         idle_d     = '0;
      end
   end

   always_ff @(posedge OSC_40) begin
      if (RESET) begin
         clk_meta_q  <= 1'b0;
         clk_s_q     <= 1'b0;
         clk_d_q     <= 1'b0;
         dat_meta_q  <= 1'b0;
         dat_s_q     <= 1'b0;
         state_q     <= StIdle;
         shreg_q     <= '0;
         bitcnt_q    <= '0;
         bytecnt_q   <= '0;
         sof_pend_q  <= 1'b0;
         idle_q      <= IdleMax;
         push_q      <= 1'b0;
         push_ok_q   <= 1'b0;
         push_data_q <= '0;
         eof_q       <= 1'b0;
         ferr_q      <= 1'b0;
         ovf_q       <= 1'b0;
         frame_len_q <= '0;
      end else begin
         clk_meta_q  <= LINK_CLK;
         clk_s_q     <= clk_meta_q;
         clk_d_q     <= clk_s_q;
         dat_meta_q  <= LINK_DAT;
         dat_s_q     <= dat_meta_q;
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         bitcnt_q    <= bitcnt_d;
         bytecnt_q   <= bytecnt_d;
         sof_pend_q  <= sof_pend_d;
         idle_q      <= idle_d;
         push_q      <= push_d;
         push_ok_q   <= push_ok_d;
         push_data_q <= push_data_d;
         eof_q       <= eof_d;
         ferr_q      <= ferr_d;
         ovf_q       <= ovf_d;
         frame_len_q <= frame_len_d;
      end
   end

   link_byte_fifo #(
      .Depth (FIFO_DEPTH),
      .Width (9)
   ) u_fifo (
      .clk_i   (OSC_40),
      .rst_i   (RESET),
      .push_i  (fifo_wr),
      .data_i  (push_data_q),
      .pop_i   (fifo_pop),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Head storage is not reset, so gate it to keep outputs at zero while empty.
   assign RX_VALID  = ~fifo_empty;
   assign RX_DATA   = fifo_empty ? 8'd0 : fifo_head[7:0];
   assign RX_SOF    = ~fifo_empty & fifo_head[8];
   assign RX_EOF    = eof_q;
   assign ERR_FRAME = ferr_q;
   assign ERR_OVF   = ovf_q;
   assign FRAME_LEN = frame_len_q;

endmodule

// File: tb/tb_conn_link_rx.sv
// Directed bench for conn_link_rx: table of whole-frame vectors plus hand-written sequences
// for idle-gap boundaries, mid-frame reset, latency and full-FIFO push/pop.
module tb_conn_link_rx;

   localparam int H = 4;  // half bit period in OSC_40 cycles (5 Mb/s)

   logic        OSC_40   = 1'b0;
   logic        RESET    = 1'b1;
   logic        LINK_CLK = 1'b0;
   logic        LINK_DAT = 1'b0;
   logic        RX_READY = 1'b0;
   logic [7:0]  RX_DATA;
   logic        RX_SOF, RX_VALID, RX_EOF, ERR_FRAME, ERR_OVF;
   logic [10:0] FRAME_LEN;

   conn_link_rx dut (
      .OSC_40    (OSC_40),
      .RESET     (RESET),
      .LINK_CLK  (LINK_CLK),
      .LINK_DAT  (LINK_DAT),
      .RX_DATA   (RX_DATA),
      .RX_SOF    (RX_SOF),
      .RX_VALID  (RX_VALID),
      .RX_READY  (RX_READY),
      .RX_EOF    (RX_EOF),
      .FRAME_LEN (FRAME_LEN),
      .ERR_FRAME (ERR_FRAME),
      .ERR_OVF   (ERR_OVF)
   );

   always #5 OSC_40 = ~OSC_40;

   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   logic rst_q = 1'b1;

   always @(posedge OSC_40) begin
      cyc   <= cyc + 1;
      rst_q <= RESET;
   end

   // Monitor: samples once per cycle, well away from the active edge.
   logic [8:0] pops[$];
   int         n_eof = 0, n_ferr = 0, n_ovf = 0, eof_cyc = 0, ferr_cyc = 0;
   int         n_unstable = 0, n_rst_bad = 0;
   logic [8:0] prev_head = '0;
   logic       prev_hold = 1'b0;

   always @(negedge OSC_40) begin
      #1;
      if (rst_q) begin
         if (RX_VALID || RX_EOF || ERR_FRAME || ERR_OVF) n_rst_bad++;
         prev_hold = 1'b0;
      end else begin
         if (prev_hold && (!RX_VALID || {RX_SOF, RX_DATA} != prev_head)) n_unstable++;
         if (RX_VALID && RX_READY) pops.push_back({RX_SOF, RX_DATA});
         if (RX_EOF) begin
            n_eof++;
            eof_cyc = cyc;
         end
         if (ERR_FRAME) begin
            n_ferr++;
            ferr_cyc = cyc;
         end
         if (ERR_OVF) n_ovf++;
         prev_hold = RX_VALID & ~RX_READY;
         prev_head = {RX_SOF, RX_DATA};
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   int last_rise = 0;

   task automatic send_bits(input logic [7:0] val, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         @(negedge OSC_40);
         LINK_CLK = 1'b0;
         LINK_DAT = val[i];
         repeat (H - 1) @(negedge OSC_40);
         @(negedge OSC_40);
         LINK_CLK  = 1'b1;
         last_rise = cyc;
         repeat (H - 1) @(negedge OSC_40);
      end
   endtask

   task automatic idle(input int n);
      @(negedge OSC_40);
      LINK_CLK = 1'b0;
      repeat (n) @(negedge OSC_40);
   endtask

   // Sends a byte with the LSB edge placed by hand so posedges after it can be counted.
   task automatic send_timed(input logic [7:0] b, input bit chk_lat, input bit pulse);
      send_bits(b >> 1, 7);
      @(negedge OSC_40);
      LINK_CLK = 1'b0;
      LINK_DAT = b[0];
      repeat (H - 1) @(negedge OSC_40);
      @(negedge OSC_40);
      LINK_CLK = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(posedge OSC_40);
         #1;
         if (chk_lat && k == 3) check("valid_before_latency", int'(RX_VALID), 0);
         if (chk_lat && k == 4) check("valid_at_latency", int'(RX_VALID), 1);
         if (pulse && k == 3) RX_READY = 1'b1;
         if (pulse && k == 4) RX_READY = 1'b0;
      end
   endtask

   typedef struct packed {
      logic [47:0] bytes;
      int          nbytes;
      logic [7:0]  xbits;
      int          nx;
      logic        ready;
      int          exp_n;
      logic [53:0] exp_pops;
      int          exp_eof;
      int          exp_ferr;
      int          exp_ovf;
      int          exp_len;
   } vec_t;

   vec_t tv[4];
   int   s_pops, s_eof, s_ferr, s_ovf, lat;

   task automatic snap();
      s_pops = pops.size();
      s_eof  = n_eof;
      s_ferr = n_ferr;
      s_ovf  = n_ovf;
   endtask

   task automatic check_pop(input string name, input int idx, input logic [8:0] exp);
      if (s_pops + idx < pops.size()) check(name, int'(pops[s_pops + idx]), int'(exp));
      else check({name, "_missing"}, 0, 1);
   endtask

   initial begin
      tv[0] = '{bytes: {8'hA5, 8'h3C, 8'hFF, 24'h0}, nbytes: 3, xbits: 8'h0, nx: 0,
                ready: 1'b1, exp_n: 3, exp_pops: {9'h1A5, 9'h03C, 9'h0FF, 27'h0},
                exp_eof: 1, exp_ferr: 0, exp_ovf: 0, exp_len: 3};
      tv[1] = '{bytes: {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}, nbytes: 6, xbits: 8'h0,
                nx: 0, ready: 1'b0, exp_n: 4,
                exp_pops: {9'h101, 9'h002, 9'h003, 9'h004, 18'h0},
                exp_eof: 1, exp_ferr: 0, exp_ovf: 2, exp_len: 6};
      tv[2] = '{bytes: {8'h80, 40'h0}, nbytes: 1, xbits: 8'h05, nx: 3, ready: 1'b1,
                exp_n: 1, exp_pops: {9'h180, 45'h0},
                exp_eof: 1, exp_ferr: 1, exp_ovf: 0, exp_len: 1};
      tv[3] = '{bytes: {8'h00, 8'h7E, 32'h0}, nbytes: 2, xbits: 8'h0, nx: 0, ready: 1'b1,
                exp_n: 2, exp_pops: {9'h100, 9'h07E, 36'h0},
                exp_eof: 1, exp_ferr: 0, exp_ovf: 0, exp_len: 2};

      // Reset state
      repeat (4) @(negedge OSC_40);
      #1;
      check("rst_valid", int'(RX_VALID), 0);
      check("rst_data", int'(RX_DATA), 0);
      check("rst_sof", int'(RX_SOF), 0);
      check("rst_frame_len", int'(FRAME_LEN), 0);
      check("rst_pulses", int'({RX_EOF, ERR_FRAME, ERR_OVF}), 0);
      @(negedge OSC_40);
      RESET = 1'b0;
      repeat (4) @(negedge OSC_40);

      for (int v = 0; v < 4; v++) begin
         snap();
         RX_READY = tv[v].ready;
         for (int i = 0; i < tv[v].nbytes; i++) send_bits(tv[v].bytes[47 - 8 * i -: 8], 8);
         if (tv[v].nx > 0) send_bits(tv[v].xbits, tv[v].nx);
         idle(100);
         RX_READY = 1'b1;
         idle(10);
         check($sformatf("v%0d_pop_count", v), pops.size() - s_pops, tv[v].exp_n);
         for (int i = 0; i < tv[v].exp_n; i++)
            check_pop($sformatf("v%0d_pop%0d", v, i), i, tv[v].exp_pops[53 - 9 * i -: 9]);
         check($sformatf("v%0d_eof", v), n_eof - s_eof, tv[v].exp_eof);
         check($sformatf("v%0d_err_frame", v), n_ferr - s_ferr, tv[v].exp_ferr);
         check($sformatf("v%0d_err_ovf", v), n_ovf - s_ovf, tv[v].exp_ovf);
         check($sformatf("v%0d_frame_len", v), int'(FRAME_LEN), tv[v].exp_len);
         if (v == 0) begin
            lat = eof_cyc - last_rise;
            check("eof_after_idle_gap", int'(lat >= 64 && lat <= 72), 1);
         end
         if (tv[v].exp_ferr > 0) check($sformatf("v%0d_ferr_with_eof", v), ferr_cyc, eof_cyc);
      end

      // Reset mid-frame: 2 bytes + 4 bits buffered, then a clean 0x55 frame
      snap();
      RX_READY = 1'b0;
      send_bits(8'hAA, 8);
      send_bits(8'hBB, 8);
      send_bits(8'h09, 4);
      idle(2);
      RESET = 1'b1;
      @(negedge OSC_40);
      #1;
      check("midrst_valid", int'(RX_VALID), 0);
      check("midrst_frame_len", int'(FRAME_LEN), 0);
      repeat (3) @(negedge OSC_40);
      RESET = 1'b0;
      idle(100);
      check("midrst_no_eof", n_eof - s_eof, 0);
      check("midrst_no_ferr", n_ferr - s_ferr, 0);
      snap();
      RX_READY = 1'b1;
      send_bits(8'h55, 8);
      idle(100);
      check("midrst_pop_count", pops.size() - s_pops, 1);
      check_pop("midrst_pop0", 0, 9'h155);
      check("midrst_eof", n_eof - s_eof, 1);
      check("midrst_frame_len", int'(FRAME_LEN), 1);

      // Gap of IDLE_CYCLES-1 non-rise cycles keeps one frame
      snap();
      send_bits(8'h11, 8);
      repeat (64 - 2 * H) @(negedge OSC_40);
      send_bits(8'h22, 8);
      idle(100);
      check("gap63_eof", n_eof - s_eof, 1);
      check("gap63_frame_len", int'(FRAME_LEN), 2);
      check("gap63_pop_count", pops.size() - s_pops, 2);
      check_pop("gap63_pop0", 0, 9'h111);
      check_pop("gap63_pop1", 1, 9'h022);

      // Gap of exactly IDLE_CYCLES non-rise cycles splits the frame
      snap();
      send_bits(8'h11, 8);
      repeat (65 - 2 * H) @(negedge OSC_40);
      send_bits(8'h22, 8);
      idle(100);
      check("gap64_eof", n_eof - s_eof, 2);
      check("gap64_frame_len", int'(FRAME_LEN), 1);
      check("gap64_pop_count", pops.size() - s_pops, 2);
      check_pop("gap64_pop0", 0, 9'h111);
      check_pop("gap64_pop1", 1, 9'h122);

      // Latency on empty FIFO, then fill and push into a full FIFO while popping
      snap();
      RX_READY = 1'b0;
      send_timed(8'hC3, 1'b1, 1'b0);
      send_bits(8'h10, 8);
      send_bits(8'h20, 8);
      send_bits(8'h30, 8);
      send_timed(8'h40, 1'b0, 1'b1);
      idle(100);
      check("full_pushpop_ovf", n_ovf - s_ovf, 0);
      check("full_pushpop_eof", n_eof - s_eof, 1);
      check("full_pushpop_len", int'(FRAME_LEN), 5);
      RX_READY = 1'b1;
      idle(10);
      check("full_pushpop_pop_count", pops.size() - s_pops, 5);
      check_pop("full_pushpop_pop0", 0, 9'h1C3);
      check_pop("full_pushpop_pop1", 1, 9'h010);
      check_pop("full_pushpop_pop4", 4, 9'h040);

      check("head_stable_while_stalled", n_unstable, 0);
      check("quiet_during_reset", n_rst_bad, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
